// File: rtl/psola_playback_if.sv
// Playback-side bundle: start/length control, sample tick, both BRAM ports and the audio sample stream.
// sample_out carries a two's-complement OUT_WIDTH-bit sample.
interface psola_playback_if #(
   parameter int LOG_WINDOW_SIZE = 11,
   parameter int OUT_WIDTH       = 16
);
   logic                     start;
   logic [LOG_WINDOW_SIZE:0] window_len;
   logic                     sample_tick;
   logic [LOG_WINDOW_SIZE:0] read_addr;
   logic [31:0]              read_val;
   logic [LOG_WINDOW_SIZE:0] clear_addr;
   logic                     clear_we;
   logic [OUT_WIDTH-1:0]     sample_out;
   logic                     sample_valid;
   logic                     busy;
   logic                     done;

   modport master (
      input  start, window_len, sample_tick, read_val,
      output read_addr, clear_addr, clear_we, sample_out, sample_valid, busy, done
   );

   modport slave (
      output start, window_len, sample_tick, read_val,
      input  read_addr, clear_addr, clear_we, sample_out, sample_valid, busy, done
   );
endinterface

// File: rtl/psola_playback.sv
// Streams the PSOLA output buffer at the sample rate, converting Q(FRAC_BITS) words to saturated
// samples and zeroing each buffer location once it has been played.
module psola_playback #(
   parameter int WINDOW_SIZE = 2048,
   parameter int FRAC_BITS   = 10,
   parameter int OUT_WIDTH   = 16
) (
   input  logic              clk_in,
   input  logic              rst_in,
   psola_playback_if.master  bus
);
   localparam int LOG_WINDOW_SIZE = $clog2(WINDOW_SIZE);
   localparam int LEN_W           = LOG_WINDOW_SIZE + 1;
   localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(WINDOW_SIZE);
   localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (OUT_WIDTH - 1)) - 32'sd1;
   localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (OUT_WIDTH - 1));

   typedef enum logic [2:0] {IDLE, WAIT, F1, F2, CAP, EMIT} state_t;

   state_t               state_reg, state_next;
   logic [LEN_W-1:0]     idx_reg, idx_next;
   logic [LEN_W-1:0]     len_reg, len_next;
   logic [LEN_W-1:0]     read_addr_reg, read_addr_next;
   logic [OUT_WIDTH-1:0] sample_reg, sample_next;
   logic                 zero_done_reg, zero_done_next;

   logic signed [31:0]   shifted;
   logic [LEN_W-1:0]     len_clamped;
   logic                 last;

   assign shifted     = $signed(bus.read_val) >>> FRAC_BITS;
   assign len_clamped = (bus.window_len > MAX_LEN) ? MAX_LEN : bus.window_len;
   assign last        = (idx_reg == len_reg - LEN_W'(1));

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         len_reg       <= '0;
         read_addr_reg <= '0;
         sample_reg    <= '0;
         zero_done_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         len_reg       <= len_next;
         read_addr_reg <= read_addr_next;
         sample_reg    <= sample_next;
         zero_done_reg <= zero_done_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      len_next       = len_reg;
      read_addr_next = read_addr_reg;
      sample_next    = sample_reg;
      zero_done_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               len_next = len_clamped;
               idx_next = '0;
               // An empty window completes immediately without ever raising busy.
               if (len_clamped == '0) begin
                  zero_done_next = 1'b1;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (bus.sample_tick) begin
               read_addr_next = idx_reg;
               state_next     = F1;
            end
         end
         F1:  state_next = F2;
         F2:  state_next = CAP;
         CAP: begin
            if (shifted > SAT_MAX) begin
               sample_next = SAT_MAX[OUT_WIDTH-1:0];
            end else if (shifted < SAT_MIN) begin
               sample_next = SAT_MIN[OUT_WIDTH-1:0];
            end else begin
               sample_next = shifted[OUT_WIDTH-1:0];
            end
            state_next = EMIT;
         end
         EMIT: begin
            if (last) begin
               state_next = IDLE;
            end else begin
               idx_next   = idx_reg + LEN_W'(1);
               state_next = WAIT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The zero-write in EMIT targets the address read three cycles earlier, so the ports never collide.
   assign bus.read_addr    = read_addr_reg;
   assign bus.clear_addr   = (state_reg == EMIT) ? idx_reg : '0;
   assign bus.clear_we     = (state_reg == EMIT);
   assign bus.sample_valid = (state_reg == EMIT);
   assign bus.sample_out   = sample_reg;
   assign bus.busy         = (state_reg != IDLE);
   assign bus.done         = ((state_reg == EMIT) && last) || zero_done_reg;

endmodule

// File: tb/tb_psola_playback.sv
// Directed bench for psola_playback: BRAM model with 2-cycle read latency, scoreboard of expected
// samples pushed at start and checked on every sample_valid strobe.
module tb_psola_playback;
   logic clk = 1'b0;
   logic rst_in;
   always #5 clk = ~clk;

   psola_playback_if #(.LOG_WINDOW_SIZE(11), .OUT_WIDTH(16)) bus ();

   psola_playback #(.WINDOW_SIZE(2048), .FRAC_BITS(10), .OUT_WIDTH(16)) dut (
      .clk_in (clk),
      .rst_in (rst_in),
      .bus    (bus)
   );

   typedef struct {
      logic [15:0] s;
      int          a;
      logic        d;
   } exp_t;

   exp_t        q[$];
   int          checks;
   int          errors;
   int          done_count;
   int          strobe_count;
   logic [31:0] mem [0:2047];
   logic [31:0] rd_pipe;
   logic        ld_we;
   logic [10:0] ld_addr;
   logic [31:0] ld_data;

   // BRAM model: preload port, zeroing port, and a 2-stage registered read port.
   always @(posedge clk) begin
      if (ld_we) mem[ld_addr] <= ld_data;
      if (bus.clear_we) mem[bus.clear_addr[10:0]] <= 32'd0;
      rd_pipe      <= mem[bus.read_addr[10:0]];
      bus.read_val <= rd_pipe;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] sat(input logic [31:0] w);
      int s;
      s = $signed(w) >>> 10;
      if (s > 32767) return 16'h7FFF;
      if (s < -32768) return 16'h8000;
      return s[15:0];
   endfunction

   always @(negedge clk) begin
      if (!rst_in) begin
         if (bus.done) done_count++;
         if (bus.sample_valid || bus.clear_we) begin
            strobe_count++;
            check("strobe_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
               exp_t e;
               e = q.pop_front();
               $display("sample addr=%0d val=%0d done=%0b", bus.clear_addr, $signed(bus.sample_out), bus.done);
               check("sample_out", {16'd0, bus.sample_out}, {16'd0, e.s});
               check("clear_addr", 32'(bus.clear_addr), 32'(e.a));
               check("clear_we", 32'(bus.clear_we), 32'd1);
               check("sample_valid", 32'(bus.sample_valid), 32'd1);
               check("done_with_last", 32'(bus.done), 32'(e.d));
            end
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load(input int a, input logic [31:0] d);
      ld_we   = 1'b1;
      ld_addr = 11'(a);
      ld_data = d;
      step();
      ld_we   = 1'b0;
   endtask

   task automatic push_exp(input logic [15:0] s, input int a, input logic d);
      exp_t e;
      e.s = s;
      e.a = a;
      e.d = d;
      q.push_back(e);
   endtask

   task automatic push_model(input int len);
      for (int i = 0; i < len; i++) push_exp(sat(mem[i]), i, i == len - 1);
   endtask

   task automatic do_start(input int len);
      bus.window_len = 12'(len);
      bus.start      = 1'b1;
      step();
      bus.start      = 1'b0;
   endtask

   // Tick in cycle T; sample_valid must stay low through T+3 and rise in T+4.
   task automatic tick_check(input string tag);
      bus.sample_tick = 1'b1;
      step();
      bus.sample_tick = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check({tag, "_early"}, 32'(bus.sample_valid), 32'd0);
         step();
      end
      check({tag, "_lat4"}, 32'(bus.sample_valid), 32'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'd0);
      check({tag, "_valid"}, 32'(bus.sample_valid), 32'd0);
      check({tag, "_we"}, 32'(bus.clear_we), 32'd0);
      check({tag, "_out"}, {16'd0, bus.sample_out}, 32'd0);
      check({tag, "_raddr"}, 32'(bus.read_addr), 32'd0);
      check({tag, "_caddr"}, 32'(bus.clear_addr), 32'd0);
   endtask

   initial begin
      int d0;
      int s0;
      checks = 0; errors = 0; done_count = 0; strobe_count = 0;
      bus.start = 1'b0; bus.window_len = '0; bus.sample_tick = 1'b0;
      ld_we = 1'b0; ld_addr = '0; ld_data = '0;
      rst_in = 1'b1;
      step(3);
      rst_in = 1'b0;
      step();
      check_idle_outputs("reset");

      // Basic playback with literal expectations.
      load(0, 32'h0000_0400); load(1, 32'hFFFF_FC00); load(2, 32'h0000_0A00);
      push_exp(16'h0001, 0, 1'b0); push_exp(16'hFFFF, 1, 1'b0); push_exp(16'h0002, 2, 1'b1);
      d0 = done_count;
      do_start(3);
      check("t1_busy", 32'(bus.busy), 32'd1);
      repeat (3) begin tick_check("t1"); step(16); end
      check("t1_done_count", 32'(done_count), 32'(d0 + 1));
      check("t1_busy_end", 32'(bus.busy), 32'd0);
      for (int i = 0; i < 3; i++) check("t1_cleared", mem[i], 32'd0);
      check("t1_queue", 32'(q.size()), 32'd0);

      // Saturation.
      load(0, 32'h7FFF_FFFF); load(1, 32'h8000_0000);
      push_exp(16'h7FFF, 0, 1'b0); push_exp(16'h8000, 1, 1'b1);
      do_start(2);
      repeat (2) begin tick_check("t2"); step(16); end
      check("t2_queue", 32'(q.size()), 32'd0);

      // Empty window.
      s0 = strobe_count; d0 = done_count;
      do_start(0);
      check("t3_done", 32'(bus.done), 32'd1);
      check("t3_busy", 32'(bus.busy), 32'd0);
      step();
      check("t3_done_off", 32'(bus.done), 32'd0);
      check("t3_busy2", 32'(bus.busy), 32'd0);
      step(5);
      check("t3_strobes", 32'(strobe_count), 32'(s0));
      check("t3_done_count", 32'(done_count), 32'(d0 + 1));

      // Tick pairs two cycles apart: the second tick lands in F2 and is ignored.
      for (int i = 0; i < 4; i++) load(i, 32'((i + 5) << 10));
      push_model(4);
      s0 = strobe_count;
      do_start(4);
      repeat (4) begin
         bus.sample_tick = 1'b1; step(); bus.sample_tick = 1'b0; step();
         bus.sample_tick = 1'b1; step(); bus.sample_tick = 1'b0; step();
         check("t4_lat4", 32'(bus.sample_valid), 32'd1);
         step(16);
      end
      check("t4_strobes", 32'(strobe_count), 32'(s0 + 4));
      check("t4_queue", 32'(q.size()), 32'd0);

      // Oversized window_len clamps to the full buffer.
      for (int i = 0; i < 2048; i++) load(i, 32'(((i * 37) % 4096 - 2048) << 10));
      push_model(2048);
      s0 = strobe_count; d0 = done_count;
      do_start(4095);
      repeat (2048) begin bus.sample_tick = 1'b1; step(); bus.sample_tick = 1'b0; step(4); end
      step(4);
      check("clamp_strobes", 32'(strobe_count), 32'(s0 + 2048));
      check("clamp_done_count", 32'(done_count), 32'(d0 + 1));
      check("clamp_busy", 32'(bus.busy), 32'd0);
      check("clamp_last_cleared", mem[2047], 32'd0);
      check("clamp_queue", 32'(q.size()), 32'd0);

      // start while busy is ignored.
      for (int i = 0; i < 5; i++) load(i, 32'(-(i + 1) * 3000));
      push_model(5);
      s0 = strobe_count; d0 = done_count;
      do_start(5);
      tick_check("t5"); step(16);
      tick_check("t5");
      bus.window_len = 12'd7; bus.start = 1'b1; step(); bus.start = 1'b0;
      step(15);
      repeat (3) begin tick_check("t5"); step(16); end
      bus.sample_tick = 1'b1; step(); bus.sample_tick = 1'b0; step(8);
      check("t5_strobes", 32'(strobe_count), 32'(s0 + 5));
      check("t5_done_count", 32'(done_count), 32'(d0 + 1));
      check("t5_queue", 32'(q.size()), 32'd0);

      // Reset in F2 of the third sample, then a fresh playback.
      for (int i = 0; i < 4; i++) load(i, 32'((i + 11) << 10));
      push_model(4);
      do_start(4);
      tick_check("t6"); step(16);
      tick_check("t6"); step(16);
      bus.sample_tick = 1'b1; step(); bus.sample_tick = 1'b0; step();
      rst_in = 1'b1; step(); rst_in = 1'b0;
      check_idle_outputs("t6_rst");
      q.delete();
      check("t6_tail2", mem[2], 32'(13 << 10));
      check("t6_tail3", mem[3], 32'(14 << 10));
      load(0, 32'h0001_2C00); load(1, 32'hFFFE_0000);
      push_model(2);
      s0 = strobe_count; d0 = done_count;
      do_start(2);
      repeat (2) begin tick_check("t6b"); step(16); end
      check("t6b_strobes", 32'(strobe_count), 32'(s0 + 2));
      check("t6b_done_count", 32'(done_count), 32'(d0 + 1));
      check("t6b_queue", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
